// File: rtl/lsu_ctrl.sv
// Load/store unit controller: sequences RV32 byte/half/word loads and stores onto a
// word-wide data memory, using read-modify-write for sub-word stores.
module lsu_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;

  state_t      state, state_next;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic        err_q;
  logic [31:0] merge_q;

  logic        illegal, misaligned, bad;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val, merge_val;

  always_comb begin
    illegal    = we_i ? (funct3_i > 3'd2)
                      : (funct3_i == 3'd3 || funct3_i == 3'd6 || funct3_i == 3'd7);
    misaligned = ((funct3_i[1:0] == 2'd1) && addr_i[0]) ||
                 ((funct3_i == 3'd2) && (addr_i[1:0] != 2'd0));
    bad        = illegal | misaligned;
  end

  always_comb begin
    byte_sel = mem_rdata_i[{off_q, 3'b000} +: 8];
    half_sel = mem_rdata_i[{off_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'd0:    load_val = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_val = {{16{half_sel[15]}}, half_sel};
      3'd4:    load_val = {24'd0, byte_sel};
      3'd5:    load_val = {16'd0, half_sel};
      default: load_val = mem_rdata_i;
    endcase
  end

  always_comb begin
    merge_val = mem_rdata_i;
    if (f3_q[1:0] == 2'd0) merge_val[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else                   merge_val[{off_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_i) state_next = bad ? DONE : ACCESS;
      ACCESS:  state_next = (we_q && f3_q != 3'd2) ? WRITE : DONE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_o   = (state != IDLE);
    done_o   = (state == DONE);
    err_o    = (state == DONE) && err_q;
    mem_wr_o = ((state == ACCESS) && we_q && (f3_q == 3'd2)) || (state == WRITE);
  end

  // merge_q doubles as the outgoing write word: loaded with the store data for sw,
  // or with the read-modify-write result for sb/sh, so mem_wdata_o holds between stores.
  assign mem_wdata_o = merge_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      merge_q    <= '0;
      rdata_o    <= '0;
      mem_addr_o <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_i) begin
        we_q       <= we_i;
        f3_q       <= funct3_i;
        off_q      <= addr_i[1:0];
        wdata_q    <= wdata_i[15:0];
        err_q      <= bad;
        mem_addr_o <= {addr_i[31:2], 2'b00};
        if (we_i && funct3_i == 3'd2 && !bad) merge_q <= wdata_i;
      end
      if (state == ACCESS) begin
        if (!we_q)               rdata_o <= load_val;
        else if (f3_q != 3'd2)   merge_q <= merge_val;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: byte-addressed reference memory predicts completions
// and memory writes; an independent monitor compares them as the DUT produces them.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_i, req_i, we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        busy_o, done_o, err_o, mem_wr_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;

  logic [31:0] dmem  [0:63];
  logic [7:0]  ref_b [0:255];
  logic [31:0] model_rdata;
  int checks = 0, errors = 0;

  typedef struct { logic err; logic [31:0] rdata; logic [31:0] addr; longint t; } done_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; longint t; } wr_t;
  done_t dq[$];
  wr_t   wq[$];

  lsu_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rdata_o(rdata_o), .mem_addr_o(mem_addr_o), .mem_wr_o(mem_wr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  assign mem_rdata_i = dmem[mem_addr_o[7:2]];
  always @(posedge clk) if (mem_wr_o) dmem[mem_addr_o[7:2]] <= mem_wdata_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin : monitor
    done_t d;
    wr_t   w;
    if (done_o) begin
      if (dq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        d = dq.pop_front();
        chk("done_time", 32'($time), 32'(d.t));
        chk("err", {31'd0, err_o}, {31'd0, d.err});
        chk("rdata", rdata_o, d.rdata);
        chk("done_addr", mem_addr_o, d.addr);
      end
    end
    if (mem_wr_o) begin
      if (wq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        w = wq.pop_front();
        chk("wr_time", 32'($time), 32'(w.t));
        chk("wr_addr", mem_addr_o, w.addr);
        chk("wr_data", mem_wdata_o, w.data);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                        input logic [31:0] wd);
    int size, a, wb, wlat;
    logic legal, aligned;
    logic [31:0] v, tmp;
    longint p;
    done_t d;
    wr_t w;
    bit idle_seen;
    size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    a       = int'(addr);
    wb      = a & ~3;
    legal   = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    aligned = (a % size) == 0;
    req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = {24'd0, addr}; wdata_i = wd;
    @(posedge clk);
    p = $time;
    d.addr = wb;
    if (!(legal && aligned)) begin
      d.err = 1'b1; d.rdata = model_rdata; d.t = p + 5;
    end else if (!we) begin
      v = '0;
      for (int i = 0; i < size; i++) v |= 32'(ref_b[a + i]) << (8 * i);
      if (f3 < 3'd4 && size < 4 && v[8 * size - 1])
        v |= (size == 1) ? 32'hFFFF_FF00 : 32'hFFFF_0000;
      model_rdata = v;
      d.err = 1'b0; d.rdata = v; d.t = p + 15;
    end else begin
      for (int i = 0; i < size; i++) begin
        tmp = wd >> (8 * i);
        ref_b[a + i] = tmp[7:0];
      end
      wlat   = (size == 4) ? 1 : 2;
      w.addr = wb;
      w.data = {ref_b[wb + 3], ref_b[wb + 2], ref_b[wb + 1], ref_b[wb]};
      w.t    = p + wlat * 10 - 5;
      wq.push_back(w);
      d.err = 1'b0; d.rdata = model_rdata; d.t = p + (wlat + 1) * 10 - 5;
    end
    dq.push_back(d);
    idle_seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (!busy_o) begin idle_seen = 1; break; end
      req_i = 1'($urandom_range(0, 1)); we_i = 1'($urandom_range(0, 1));
      funct3_i = 3'($urandom_range(0, 7)); addr_i = $urandom; wdata_i = $urandom;
    end
    req_i = 1'b0;
    if (!idle_seen) chk("timeout_busy", 32'd1, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_b[i] = 8'($urandom);
    ref_b[16] = 8'hDD; ref_b[17] = 8'hCC; ref_b[18] = 8'hBB; ref_b[19] = 8'hAA;
    for (int i = 0; i < 64; i++)
      dmem[i] = {ref_b[4*i + 3], ref_b[4*i + 2], ref_b[4*i + 1], ref_b[4*i]};
    model_rdata = '0;
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; funct3_i = '0; addr_i = '0; wdata_i = '0;
    #1;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_wr", {31'd0, mem_wr_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;

    do_txn(1'b0, 3'd0, 8'h11, '0);          chk("lb_0x11", rdata_o, 32'hFFFF_FFCC);
    do_txn(1'b0, 3'd4, 8'h11, '0);          chk("lbu_0x11", rdata_o, 32'h0000_00CC);
    do_txn(1'b0, 3'd5, 8'h12, '0);          chk("lhu_0x12", rdata_o, 32'h0000_AABB);
    do_txn(1'b1, 3'd0, 8'h13, 32'h11);      chk("sb_mem", dmem[4], 32'h11BB_CCDD);
    do_txn(1'b0, 3'd2, 8'h10, '0);
    do_txn(1'b1, 3'd2, 8'h20, 32'h1234_5678);
    do_txn(1'b0, 3'd2, 8'h20, '0);          chk("lw_0x20", rdata_o, 32'h1234_5678);
    do_txn(1'b0, 3'd2, 8'h22, '0);          chk("lw_mis_hold", rdata_o, 32'h1234_5678);
    do_txn(1'b1, 3'd1, 8'h31, 32'hBEEF);

    // Reset in the ACCESS state of an sh: aborted, no write, no completion.
    req_i = 1'b1; we_i = 1'b1; funct3_i = 3'd1; addr_i = 32'h40; wdata_i = 32'hCAFE;
    @(posedge clk);
    @(negedge clk);
    req_i = 1'b0;
    chk("sh_busy", {31'd0, busy_o}, 32'd1);
    #1 rst_i = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_wr", {31'd0, mem_wr_o}, 32'd0);
    chk("abort_rdata", rdata_o, 32'd0);
    model_rdata = '0;
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    do_txn(1'b0, 3'd2, 8'h40, '0);

    for (int k = 0; k < 300; k++)
      do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), $urandom);

    repeat (4) @(negedge clk);
    chk("pending_done", 32'(dq.size()), 32'd0);
    chk("pending_writes", 32'(wq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk_i and rst_i.
REQ-002 clk_i  input  1  system clock; all state updates on rising edge.
REQ-003 rst_i  input  1  asynchronous active-high reset.
REQ-004 req_i  input  1  CPU access request; sampled only when busy_o=0.
REQ-005 we_i  input  1  1=store, 0=load; sampled with req_i.
REQ-006 funct3_i  input  3  RV32 width code: 0=b, 1=h, 2=w, 4=bu, 5=hu.
REQ-007 addr_i  input  32  byte address; sampled with req_i.
REQ-008 wdata_i  input  32  store data, right-aligned; sampled with req_i.
REQ-009 busy_o  output  1  high whenever the state is not IDLE.
REQ-010 done_o  output  1  one-cycle completion pulse.
REQ-011 err_o  output  1  valid with done_o; misaligned or illegal funct3.
REQ-012 rdata_o  output  32  extended load result; registered.
REQ-013 mem_addr_o  output  32  word address {addr[31:2],2'b00} to the data memory.
REQ-014 mem_wr_o  output  1  word write enable to the data memory.
REQ-015 mem_wdata_o  output  32  full word to write.
REQ-016 mem_rdata_i  input  32  combinational read data for mem_addr_o.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS, WRITE, DONE; acceptance is req_i=1 in IDLE at a rising edge, which latches we_i, funct3_i, addr_i and wdata_i.
REQ-018 Legal and aligned request SHALL go IDLE->ACCESS; any illegal or misaligned request SHALL go IDLE->DONE with err_o=1 and no memory write.
REQ-019 Illegal requests: load funct3 in {3,6,7}; store funct3 >2. Misaligned requests: h/hu with addr[0]=1; w with addr[1:0]!=0.
REQ-020 ACCESS SHALL drive mem_addr_o from the latched address; for sw, ACCESS SHALL assert mem_wr_o=1 with mem_wdata_o=latched wdata, then go to DONE.
REQ-021 For loads, rdata_o SHALL be loaded at the ACCESS->DONE edge from mem_rdata_i. The selected byte is addr[1:0]*8 and the selected half is addr[1]*16. b/h are sign-extended; bu/hu are zero-extended; w passes through.
REQ-022 For sb/sh, mem_wr_o SHALL be 0 in ACCESS. mem_rdata_i SHALL be merged with the store byte/half into a merge register at lanes addr[1:0] (byte) or addr[1] (half), then ACCESS->WRITE.
REQ-023 WRITE SHALL assert mem_wr_o=1 with mem_wdata_o=merge register and the same mem_addr_o, then go to DONE.
REQ-024 DONE SHALL assert done_o=1 for exactly one cycle, then return to IDLE; err_o=0 in DONE for successful accesses.
REQ-025 Latency from the accepting edge to done_o high SHALL be: loads and sw 2 cycles; sb/sh 3 cycles; errors 1 cycle.
REQ-026 mem_wr_o SHALL be high only in ACCESS(sw) or WRITE, for exactly one cycle per store.
REQ-027 req_i while busy_o=1 SHALL be ignored, not queued; back-to-back accepts are possible from the cycle after DONE.
REQ-028 Outside ACCESS and WRITE, mem_wdata_o SHALL hold its last value and mem_addr_o SHALL hold the last latched word address.
REQ-029 rdata_o SHALL update only on a successful load, and hold otherwise.

Reset
REQ-030 rst_i=1 SHALL immediately force state IDLE, busy_o=0, done_o=0, err_o=0, mem_wr_o=0, rdata_o=0, mem_addr_o=0, mem_wdata_o=0, and clear the merge register.
REQ-031 Reset during ACCESS or WRITE SHALL abort the access; the pending write is never issued and no done_o is produced.

Verification
REQ-032 Word-aligned 0x10=0xAABBCCDD, lb addr 0x11 -> done_o at cycle 2, rdata_o=0xFFFFFFCC; lbu -> 0x000000CC; lhu 0x12 -> 0x0000AABB.
REQ-033 sb 0x13 data 0x00000011 onto 0xAABBCCDD -> one mem_wr_o pulse at cycle 2 with mem_wdata_o=0x11BBCCDD; done_o at cycle 3.
REQ-034 sw 0x20 data 0x12345678 -> mem_wr_o in ACCESS only, addr 0x20; a following lw 0x20 returns 0x12345678.
REQ-035 lw 0x22 and sh 0x31 -> done_o+err_o at cycle 1, mem_wr_o never asserted, rdata_o unchanged.
REQ-036 rst_i pulsed in ACCESS of sh -> busy_o=0 at once, no mem_wr_o, memory unchanged; req_i asserted while busy_o=1 -> ignored (no extra done_o).
